// File: rtl/freq_sweep_tracker_pkg.sv
// Shared types and constants for the resonant-frequency sweep/tracking block.
//   state_t        FSM state encoding
//   PROGRAM_FREQ   program code that enables the frequency algorithm
//   DEF_*          default cycle counts for a 100 MHz clk
//   CNT_W          width of the shared startup/settle/gap down-counter
package freq_sweep_tracker_pkg;

  typedef enum logic [3:0] {
    IDLE,
    STARTUP,
    SETTLE,
    ACQ,
    EVAL,
    DONE,
    TRACK_C,
    TRACK_U,
    TRACK_D
  } state_t;

  localparam logic [1:0] PROGRAM_FREQ = 2'b01;

  localparam int DEF_STARTUP_CYC = 200000;
  localparam int DEF_SETTLE_CYC  = 100000;
  localparam int DEF_AVG_LOG2    = 4;
  localparam int DEF_TRACK_GAP   = 1000000;

  localparam int CNT_W = 32;

  function automatic logic is_busy(input state_t s);
    return !((s == IDLE) || (s == DONE));
  endfunction

endpackage

// File: rtl/freq_sweep_tracker_adc_averager.sv
// Accumulates 2^AVG_LOG2 qualified ADC samples and reports their truncated mean.
// The result is presented combinationally in the same cycle as the final sample
// so the caller can register it and move on without an extra wait state.
//   clk          clock
//   nrst         synchronous active-low reset
//   i_clear      drop any partial accumulation
//   i_valid      sample strobe
//   i_sample     ADC sample
//   o_avg        mean of the current block (valid while o_avg_valid is high)
//   o_avg_valid  high on the cycle carrying the last sample of a block
module adc_averager #(
  parameter int ADC_W    = 12,
  parameter int AVG_LOG2 = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             i_clear,
  input  logic             i_valid,
  input  logic [ADC_W-1:0] i_sample,
  output logic [ADC_W-1:0] o_avg,
  output logic             o_avg_valid
);

  localparam int ACC_W = ADC_W + AVG_LOG2;
  localparam int SCNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [SCNT_W-1:0] LAST = SCNT_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0]  r_acc;
  logic [SCNT_W-1:0] r_cnt;
  logic [ACC_W-1:0]  w_sum;

  assign w_sum       = r_acc + ACC_W'(i_sample);
  assign o_avg_valid = i_valid && (r_cnt == LAST);
  assign o_avg       = w_sum[ACC_W-1:AVG_LOG2];

  always_ff @(posedge clk) begin
    if (!nrst || i_clear || o_avg_valid) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_valid) begin
      r_acc <= w_sum;
      r_cnt <= r_cnt + SCNT_W'(1);
    end
  end

endmodule

// File: rtl/freq_sweep_tracker.sv
// Resonant-frequency search: sweeps the drive frequency over a window, averages
// rectified-voltage samples per point, locks the peak and optionally follows drift
// with perturb-and-observe rounds.
//   clk            clock
//   nrst           synchronous active-low reset
//   i_swipt_alive  link alive; low acts like reset
//   i_program      mode select; PROGRAM_FREQ runs the algorithm
//   i_adc          ADC sample, qualified by i_adc_valid
//   i_adc_valid    one-cycle sample strobe
//   i_freq_init    frequency driven while idle
//   i_freq_min     sweep lower bound (latched when leaving IDLE)
//   i_freq_max     sweep upper bound (latched)
//   i_freq_step    sweep/track step (latched)
//   i_track_en     run tracking rounds once the sweep is done
//   o_new_freq     frequency to drive now
//   o_best_freq    best frequency found
//   o_best_adc     averaged ADC at o_best_freq
//   o_alg_done     sweep complete (sticky)
//   o_busy         high outside IDLE/DONE
//   o_cfg_err      illegal configuration seen (sticky)
//
// state   | meaning
// IDLE    | drive i_freq_init, wait for program
// STARTUP | initial settling after enable
// SETTLE  | settling after a sweep step
// ACQ     | averaging samples of the current sweep point
// EVAL    | compare against best, step or finish
// DONE    | drive best, count gap before a tracking round
// TRACK_C | re-measure centre (settle then acquire)
// TRACK_U | measure centre + step
// TRACK_D | measure centre - step
module freq_sweep_tracker
  import freq_sweep_tracker_pkg::*;
#(
  parameter int FREQ_W      = 20,
  parameter int ADC_W       = 12,
  parameter int STARTUP_CYC = DEF_STARTUP_CYC,
  parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
  parameter int AVG_LOG2    = DEF_AVG_LOG2,
  parameter int TRACK_GAP   = DEF_TRACK_GAP
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              i_swipt_alive,
  input  logic [1:0]        i_program,
  input  logic [ADC_W-1:0]  i_adc,
  input  logic              i_adc_valid,
  input  logic [FREQ_W-1:0] i_freq_init,
  input  logic [FREQ_W-1:0] i_freq_min,
  input  logic [FREQ_W-1:0] i_freq_max,
  input  logic [FREQ_W-1:0] i_freq_step,
  input  logic              i_track_en,
  output logic [FREQ_W-1:0] o_new_freq,
  output logic [FREQ_W-1:0] o_best_freq,
  output logic [ADC_W-1:0]  o_best_adc,
  output logic              o_alg_done,
  output logic              o_busy,
  output logic              o_cfg_err
);

  localparam logic [CNT_W-1:0] LD_STARTUP = CNT_W'(STARTUP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_SETTLE  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] LD_GAP     = CNT_W'(TRACK_GAP - 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [FREQ_W-1:0] r_new_freq;
  logic [FREQ_W-1:0] r_best_freq;
  logic [ADC_W-1:0]  r_best_adc;
  logic              r_alg_done;
  logic              r_cfg_err;
  logic [FREQ_W-1:0] r_min;
  logic [FREQ_W-1:0] r_max;
  logic [FREQ_W-1:0] r_step;
  logic [FREQ_W-1:0] r_ctr;
  logic              r_trk_acq;
  logic [ADC_W-1:0]  r_avg;

  logic              w_rst;
  logic              w_track;
  logic              w_acq;
  logic [ADC_W-1:0]  w_avg;
  logic              w_avg_valid;
  logic              w_cfg_ok;
  logic [FREQ_W:0]   w_nxt;
  logic              w_nxt_ok;
  logic [FREQ_W:0]   w_up_sum;
  logic [FREQ_W-1:0] w_up;
  logic [FREQ_W-1:0] w_dn_gap;
  logic [FREQ_W-1:0] w_dn;
  logic              w_better;

  assign w_rst   = !nrst || !i_swipt_alive;
  assign w_track = (r_state == TRACK_C) || (r_state == TRACK_U) || (r_state == TRACK_D);
  assign w_acq   = (r_state == ACQ) || (w_track && r_trk_acq);

  adc_averager #(
    .ADC_W    (ADC_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg (
    .clk         (clk),
    .nrst        (!w_rst),
    .i_clear     (!w_acq),
    .i_valid     (i_adc_valid && w_acq),
    .i_sample    (i_adc),
    .o_avg       (w_avg),
    .o_avg_valid (w_avg_valid)
  );

  // One extra bit so a step past the top of the frequency range cannot wrap.
  assign w_nxt    = {1'b0, r_new_freq} + {1'b0, r_step};
  assign w_nxt_ok = (w_nxt <= {1'b0, r_max});

  assign w_up_sum = {1'b0, r_ctr} + {1'b0, r_step};
  assign w_up     = (w_up_sum > {1'b0, r_max}) ? r_max : w_up_sum[FREQ_W-1:0];
  // Compare the distance to the floor first so the subtraction never borrows.
  assign w_dn_gap = r_ctr - r_min;
  assign w_dn     = (w_dn_gap >= r_step) ? (r_ctr - r_step) : r_min;

  assign w_cfg_ok = (r_step != '0) && (r_min <= r_max);
  assign w_better = (w_avg > r_best_adc);

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_new_freq  <= i_freq_init;
      r_best_freq <= i_freq_init;
      r_best_adc  <= '0;
      r_alg_done  <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_min       <= '0;
      r_max       <= '0;
      r_step      <= '0;
      r_ctr       <= '0;
      r_trk_acq   <= 1'b0;
      r_avg       <= '0;
    end else if (i_program != PROGRAM_FREQ) begin
      // Done/error flags survive a mode change; everything else returns to idle.
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_new_freq  <= i_freq_init;
      r_best_freq <= i_freq_init;
      r_best_adc  <= '0;
      r_trk_acq   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_min       <= i_freq_min;
          r_max       <= i_freq_max;
          r_step      <= i_freq_step;
          r_best_adc  <= '0;
          r_trk_acq   <= 1'b0;
          r_new_freq  <= i_freq_min;
          r_best_freq <= i_freq_min;
          if ((i_freq_step == '0) || (i_freq_min > i_freq_max)) begin
            r_cfg_err  <= 1'b1;
            r_alg_done <= 1'b1;
            r_cnt      <= LD_GAP;
            r_state    <= DONE;
          end else begin
            r_cnt   <= LD_STARTUP;
            r_state <= STARTUP;
          end
        end

        STARTUP, SETTLE: begin
          if (r_cnt == '0) r_state <= ACQ;
          else             r_cnt   <= r_cnt - CNT_W'(1);
        end

        ACQ: begin
          if (w_avg_valid) begin
            r_avg   <= w_avg;
            r_state <= EVAL;
          end
        end

        EVAL: begin
          // Strict compare: on a tie the earlier (lower) frequency is kept.
          if (r_avg > r_best_adc) begin
            r_best_adc  <= r_avg;
            r_best_freq <= r_new_freq;
          end
          if (w_nxt_ok) begin
            r_new_freq <= w_nxt[FREQ_W-1:0];
            r_cnt      <= LD_SETTLE;
            r_state    <= SETTLE;
          end else begin
            r_new_freq <= (r_avg > r_best_adc) ? r_new_freq : r_best_freq;
            r_alg_done <= 1'b1;
            r_cnt      <= LD_GAP;
            r_state    <= DONE;
          end
        end

        DONE: begin
          r_new_freq <= r_best_freq;
          r_trk_acq  <= 1'b0;
          if (!i_track_en || !w_cfg_ok) begin
            r_cnt <= LD_GAP;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_ctr   <= r_best_freq;
            r_cnt   <= LD_SETTLE;
            r_state <= TRACK_C;
          end
        end

        TRACK_C, TRACK_U, TRACK_D: begin
          if (!r_trk_acq) begin
            if (r_cnt == '0) r_trk_acq <= 1'b1;
            else             r_cnt     <= r_cnt - CNT_W'(1);
          end else if (w_avg_valid) begin
            r_trk_acq <= 1'b0;
            r_cnt     <= LD_SETTLE;
            // Centre refreshes the reference unconditionally; neighbours must beat it.
            if (r_state == TRACK_C) begin
              r_best_adc <= w_avg;
            end else if (w_better) begin
              r_best_adc  <= w_avg;
              r_best_freq <= r_new_freq;
            end
            // Neighbours that clamp onto the centre are not measured.
            if ((r_state == TRACK_C) && (w_up != r_ctr)) begin
              r_new_freq <= w_up;
              r_state    <= TRACK_U;
            end else if ((r_state != TRACK_D) && (w_dn != r_ctr)) begin
              r_new_freq <= w_dn;
              r_state    <= TRACK_D;
            end else begin
              r_new_freq <= ((r_state != TRACK_C) && w_better) ? r_new_freq : r_best_freq;
              r_cnt      <= LD_GAP;
              r_state    <= DONE;
            end
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_new_freq  = r_new_freq;
  assign o_best_freq = r_best_freq;
  assign o_best_adc  = r_best_adc;
  assign o_alg_done  = r_alg_done;
  assign o_cfg_err   = r_cfg_err;
  assign o_busy      = is_busy(r_state);

endmodule

// File: tb/tb_freq_sweep_tracker.sv
// Directed bench for freq_sweep_tracker with short timing parameters.
// A frequency-dependent ADC model feeds the DUT; sweep results come from a vector
// table, abort/mode-change/tracking corners from hand-written sequences.
module tb_freq_sweep_tracker;

  localparam int FREQ_W = 20;
  localparam int ADC_W  = 12;

  logic              clk = 1'b0;
  logic              nrst;
  logic              swipt_alive;
  logic [1:0]        prog;
  logic [ADC_W-1:0]  adc;
  logic              adc_valid;
  logic [FREQ_W-1:0] freq_init, freq_min, freq_max, freq_step;
  logic              track_en;
  logic [FREQ_W-1:0] new_freq, best_freq;
  logic [ADC_W-1:0]  best_adc;
  logic              alg_done, busy, cfg_err;

  always #5 clk = ~clk;

  freq_sweep_tracker #(
    .FREQ_W      (FREQ_W),
    .ADC_W       (ADC_W),
    .STARTUP_CYC (20),
    .SETTLE_CYC  (10),
    .AVG_LOG2    (2),
    .TRACK_GAP   (50)
  ) dut (
    .clk           (clk),
    .nrst          (nrst),
    .i_swipt_alive (swipt_alive),
    .i_program     (prog),
    .i_adc         (adc),
    .i_adc_valid   (adc_valid),
    .i_freq_init   (freq_init),
    .i_freq_min    (freq_min),
    .i_freq_max    (freq_max),
    .i_freq_step   (freq_step),
    .i_track_en    (track_en),
    .o_new_freq    (new_freq),
    .o_best_freq   (best_freq),
    .o_best_adc    (best_adc),
    .o_alg_done    (alg_done),
    .o_busy        (busy),
    .o_cfg_err     (cfg_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int profile = 0;
  bit valid_all = 1'b0;
  int tick = 0;
  int vidx = 0;

  function automatic logic [ADC_W-1:0] adc_model(input int prof, input logic [FREQ_W-1:0] f,
                                                 input int idx);
    case (prof)
      0: return (f == 20'd120) ? 12'd900 : 12'd100;
      1: return ((f == 20'd110) || (f == 20'd130)) ? 12'd500 : 12'd0;
      2: return 12'd100;
      3: return 12'd0;
      4: return ((idx % 2) == 0) ? 12'd3 : 12'd4;
      5: return (f == 20'd130) ? 12'd900 : ((f == 20'd120) ? 12'd500 : 12'd100);
      6: return (f == 20'd140) ? 12'd900 : 12'd100;
      default: return 12'd0;
    endcase
  endfunction

  // ADC front-end model: samples valid two cycles in three (or always), junk when invalid.
  always @(negedge clk) begin
    logic v;
    v = valid_all || ((tick % 3) != 2);
    tick = tick + 1;
    adc_valid = v;
    if (v) begin
      adc = adc_model(profile, new_freq, vidx);
      vidx = vidx + 1;
    end else begin
      adc = 12'd4000;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [FREQ_W-1:0] fmin;
    logic [FREQ_W-1:0] fmax;
    logic [FREQ_W-1:0] fstep;
    int                prof;
    logic [FREQ_W-1:0] e_best;
    logic [ADC_W-1:0]  e_adc;
    bit                e_err;
    int                e_pts;
    logic [FREQ_W-1:0] e_maxobs;
    int                budget;
  } vec_t;

  vec_t vecs[8];

  task automatic do_reset();
    nrst = 1'b0;
    prog = 2'b00;
    track_en = 1'b0;
    swipt_alive = 1'b1;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_sweep(input vec_t v, output int cyc, output int pts,
                           output logic [FREQ_W-1:0] maxobs, output bit done);
    logic [FREQ_W-1:0] prev;
    profile   = v.prof;
    freq_min  = v.fmin;
    freq_max  = v.fmax;
    freq_step = v.fstep;
    prev   = new_freq;
    pts    = 0;
    maxobs = '0;
    cyc    = 0;
    done   = 1'b0;
    prog   = 2'b01;
    while (!done && (cyc < v.budget)) begin
      @(negedge clk);
      cyc++;
      if (busy && (new_freq != prev)) pts++;
      if (busy && (new_freq > maxobs)) maxobs = new_freq;
      prev = new_freq;
      done = alg_done;
    end
  endtask

  initial begin
    int cyc, pts, n, c_c, c_d, c_o;
    logic [FREQ_W-1:0] maxobs;
    bit done, held, rerun;
    vec_t vt;

    vecs[0] = '{20'd100, 20'd140, 20'd10, 0, 20'd120, 12'd900, 1'b0, 5, 20'd140, 3000};
    vecs[1] = '{20'd100, 20'd140, 20'd10, 1, 20'd110, 12'd500, 1'b0, 5, 20'd140, 3000};
    vecs[2] = '{20'd100, 20'd135, 20'd10, 0, 20'd120, 12'd900, 1'b0, 4, 20'd130, 3000};
    vecs[3] = '{20'd1048557, 20'd1048575, 20'd5, 2, 20'd1048557, 12'd100, 1'b0, 4,
                20'd1048572, 3000};
    vecs[4] = '{20'd200, 20'd200, 20'd1, 4, 20'd200, 12'd3, 1'b0, 1, 20'd200, 3000};
    vecs[5] = '{20'd100, 20'd130, 20'd10, 3, 20'd100, 12'd0, 1'b0, 4, 20'd130, 3000};
    vecs[6] = '{20'd100, 20'd140, 20'd0, 0, 20'd100, 12'd0, 1'b1, 0, 20'd0, 2};
    vecs[7] = '{20'd150, 20'd100, 20'd10, 0, 20'd150, 12'd0, 1'b1, 0, 20'd0, 2};

    // Reset state, held in reset even with the algorithm selected.
    freq_init = 20'd7;
    freq_min = 20'd100; freq_max = 20'd140; freq_step = 20'd10;
    swipt_alive = 1'b1; track_en = 1'b0; prog = 2'b01; nrst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_new_freq", new_freq, 7);
    check("rst_best_freq", best_freq, 7);
    check("rst_best_adc", best_adc, 0);
    check("rst_alg_done", alg_done, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_busy", busy, 0);
    prog = 2'b00;
    nrst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      do_reset();
      run_sweep(vecs[i], cyc, pts, maxobs, done);
      check($sformatf("v%0d_done_in_budget", i), done, 1);
      check($sformatf("v%0d_best_freq", i), best_freq, vecs[i].e_best);
      check($sformatf("v%0d_best_adc", i), best_adc, vecs[i].e_adc);
      check($sformatf("v%0d_new_freq", i), new_freq, vecs[i].e_best);
      check($sformatf("v%0d_cfg_err", i), cfg_err, vecs[i].e_err);
      check($sformatf("v%0d_busy", i), busy, 0);
      check($sformatf("v%0d_points", i), pts, vecs[i].e_pts);
      check($sformatf("v%0d_max_point", i), maxobs, vecs[i].e_maxobs);
    end

    // Link loss mid-acquisition, restart, then leave the frequency mode.
    do_reset();
    profile = 0; valid_all = 1'b0;
    freq_min = 20'd100; freq_max = 20'd140; freq_step = 20'd10;
    prog = 2'b01;
    repeat (23) @(negedge clk);
    check("abort_pre_busy", busy, 1);
    check("abort_pre_freq", new_freq, 100);
    swipt_alive = 1'b0;
    @(negedge clk);
    check("abort_new_freq", new_freq, 7);
    check("abort_best_freq", best_freq, 7);
    check("abort_alg_done", alg_done, 0);
    check("abort_busy", busy, 0);
    swipt_alive = 1'b1;
    run_sweep(vecs[0], cyc, pts, maxobs, done);
    check("restart_done", done, 1);
    check("restart_best_freq", best_freq, 120);
    prog = 2'b00;
    @(negedge clk);
    check("prog00_alg_done", alg_done, 1);
    check("prog00_new_freq", new_freq, 7);
    check("prog00_best_freq", best_freq, 7);
    check("prog00_best_adc", best_adc, 0);
    check("prog00_busy", busy, 0);

    // Tracking: peak drifts from 120 to 130 after the sweep.
    do_reset();
    track_en = 1'b1;
    run_sweep(vecs[0], cyc, pts, maxobs, done);
    check("trk_sweep_done", done, 1);
    check("trk_sweep_best", best_freq, 120);
    profile = 5;
    n = 0;
    while (!busy && (n < 200)) begin @(negedge clk); n++; end
    check("trk_round_start", busy, 1);
    held = 1'b1;
    n = 0;
    while (busy && (n < 200)) begin
      if (!alg_done) held = 1'b0;
      @(negedge clk); n++;
    end
    check("trk_round_end", busy, 0);
    check("trk_done_held", held, 1);
    check("trk_best_freq", best_freq, 130);
    check("trk_best_adc", best_adc, 900);
    @(negedge clk);
    check("trk_new_freq", new_freq, 130);

    // Tracking at the upper bound: only centre and down are measured; enable drops mid-round.
    do_reset();
    valid_all = 1'b1;
    track_en = 1'b1;
    vt = vecs[0];
    vt.prof = 6;
    run_sweep(vt, cyc, pts, maxobs, done);
    check("edge_sweep_best", best_freq, 140);
    n = 0;
    while (!busy && (n < 200)) begin @(negedge clk); n++; end
    check("edge_round_start", busy, 1);
    track_en = 1'b0;
    c_c = 0; c_d = 0; c_o = 0;
    n = 0;
    while (busy && (n < 200)) begin
      if (new_freq == 20'd140) c_c++;
      else if (new_freq == 20'd130) c_d++;
      else c_o++;
      @(negedge clk); n++;
    end
    check("edge_centre_cycles", c_c, 14);
    check("edge_down_cycles", c_d, 14);
    check("edge_other_cycles", c_o, 0);
    check("edge_best_freq", best_freq, 140);
    check("edge_best_adc", best_adc, 900);
    rerun = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (busy) rerun = 1'b1;
    end
    check("edge_no_more_rounds", rerun, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
